line_hit_scheduler: RTL and testbench

LINE_HIT_SCHEDULER -- requirements
Module: line_hit_scheduler

---
 rtl/line_sched_pkg.sv | 30 +++
 rtl/pixel_on_line.sv | 37 +++
 rtl/line_hit_scheduler.sv | 151 +++++++++++++++
 tb/tb_line_hit_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sched_pkg.sv
// Shared types and Q16.16 helpers for the line-hit scheduler.
// Optional feature macro used by the top: LINE_HIT_EARLY_EXIT_EN.
package line_sched_pkg;

  localparam int Q_FRAC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [31:0] x0;
    logic signed [31:0] y0;
    logic signed [31:0] xn;
    logic signed [31:0] yn;
    logic signed [31:0] mag;
    logic               en;
  } line_desc_t;

  // Q16.16 multiply: full 64-bit product, result taken from bits [47:16].
  function automatic logic signed [31:0] q_mul(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] p;
    p = a * b;
    return p[Q_FRAC+31:Q_FRAC];
  endfunction

endpackage

// File: rtl/pixel_on_line.sv
// Single-cycle point-to-segment test: pixel lies within the segment's length
// along the unit direction and within sqrt(LINE_WIDTH_SQR) of the line.
module pixel_on_line
  import line_sched_pkg::*;
#(
  parameter int LINE_WIDTH_SQR = 4
) (
  input  logic [31:0] i_px_x,
  input  logic [31:0] i_px_y,
  input  logic [31:0] i_x0,
  input  logic [31:0] i_y0,
  input  logic [31:0] i_xn,
  input  logic [31:0] i_yn,
  input  logic [31:0] i_mag,
  output logic        o_on_line
);

  localparam logic signed [31:0] W_THR = LINE_WIDTH_SQR * (1 << Q_FRAC);

  logic signed [31:0] w_dx;
  logic signed [31:0] w_dy;
  logic signed [31:0] w_t;
  logic signed [31:0] w_perp;
  logic signed [31:0] w_sq;

  assign w_dx = $signed(i_px_x) - $signed(i_x0);
  assign w_dy = $signed(i_px_y) - $signed(i_y0);

  // Projection onto the direction and signed perpendicular offset.
  assign w_t    = q_mul(w_dx, $signed(i_xn)) + q_mul(w_dy, $signed(i_yn));
  assign w_perp = q_mul(w_dx, $signed(i_yn)) - q_mul(w_dy, $signed(i_xn));
  assign w_sq   = q_mul(w_perp, w_perp);

  assign o_on_line = (w_t >= 0) && (w_t <= $signed(i_mag)) &&
                     (w_sq >= 0) && (w_sq <= W_THR);

endmodule

// File: rtl/line_hit_scheduler.sv
// Scans a small line-descriptor table one entry per cycle for a pixel and
// reports the lowest-index hit. Optional macro: LINE_HIT_EARLY_EXIT_EN.
module line_hit_scheduler
  import line_sched_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int LINE_WIDTH_SQR = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         cfg_we_in,
  input  logic [$clog2(NUM_LINES)-1:0] cfg_idx_in,
  input  logic                         cfg_en_in,
  input  logic [31:0]                  cfg_x0_in,
  input  logic [31:0]                  cfg_y0_in,
  input  logic [31:0]                  cfg_xn_in,
  input  logic [31:0]                  cfg_yn_in,
  input  logic [31:0]                  cfg_mag_in,
  output logic                         cfg_ready_out,
  input  logic                         px_valid_in,
  output logic                         px_ready_out,
  input  logic [31:0]                  px_x_in,
  input  logic [31:0]                  px_y_in,
  output logic                         res_valid_out,
  input  logic                         res_ready_in,
  output logic                         res_hit_out,
  output logic [$clog2(NUM_LINES)-1:0] res_idx_out,
  output logic [31:0]                  res_x_out,
  output logic [31:0]                  res_y_out,
  output logic                         busy_out
);

  localparam int IW = $clog2(NUM_LINES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LINES - 1);

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_hit;
  logic [IW-1:0] r_res_idx;
  logic [31:0]   r_px_x;
  logic [31:0]   r_px_y;
  line_desc_t    r_tbl [NUM_LINES];

  logic       w_idle;
  logic       w_accept;
  logic       w_cfg_wr;
  logic       w_last;
  logic       w_on_line;
  logic       w_entry_hit;
  line_desc_t w_cur;
  line_desc_t w_cfg_desc;

  assign w_idle        = (r_state == IDLE);
  assign px_ready_out  = w_idle && !rst_in;
  assign cfg_ready_out = w_idle && !rst_in;
  assign w_accept      = px_valid_in && px_ready_out;
  assign w_cfg_wr      = cfg_we_in && cfg_ready_out;
  assign w_last        = (r_idx == LAST_IDX);

  assign w_cfg_desc = '{x0:  cfg_x0_in,
                        y0:  cfg_y0_in,
                        xn:  cfg_xn_in,
                        yn:  cfg_yn_in,
                        mag: cfg_mag_in,
                        en:  cfg_en_in};

  // Descriptor payload is left as-is on reset; only the enables are cleared.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tbl[i].en <= 1'b0;
      end
    end else if (w_cfg_wr) begin
      r_tbl[cfg_idx_in] <= w_cfg_desc;
    end
  end

  assign w_cur = r_tbl[r_idx];

  pixel_on_line #(
    .LINE_WIDTH_SQR(LINE_WIDTH_SQR)
  ) u_dist (
    .i_px_x   (r_px_x),
    .i_px_y   (r_px_y),
    .i_x0     (w_cur.x0),
    .i_y0     (w_cur.y0),
    .i_xn     (w_cur.xn),
    .i_yn     (w_cur.yn),
    .i_mag    (w_cur.mag),
    .o_on_line(w_on_line)
  );

  assign w_entry_hit = w_cur.en && w_on_line;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_res_idx <= '0;
      r_px_x    <= '0;
      r_px_y    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_px_x    <= px_x_in;
            r_px_y    <= px_y_in;
            r_hit     <= 1'b0;
            r_res_idx <= '0;
            r_idx     <= '0;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (w_entry_hit && !r_hit) begin
            r_hit     <= 1'b1;
            r_res_idx <= r_idx;
          end
          // The index parks on the last entry so the scan never wraps.
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
`ifdef LINE_HIT_EARLY_EXIT_EN
          if (w_last || w_entry_hit) begin
            r_state <= DONE;
          end
`else
          if (w_last) begin
            r_state <= DONE;
          end
`endif
        end
        DONE: begin
          if (res_ready_in) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid_out = (r_state == DONE);
  assign res_hit_out   = r_hit;
  assign res_idx_out   = r_res_idx;
  assign res_x_out     = r_px_x;
  assign res_y_out     = r_px_y;
  assign busy_out      = !w_idle;

endmodule

// File: tb/tb_line_hit_scheduler.sv
// Bench for line_hit_scheduler: directed scenarios plus randomized tables and
// pixels checked against an integer-pixel geometric reference model.
module tb_line_hit_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          cfg_we_in;
  logic [IW-1:0] cfg_idx_in;
  logic          cfg_en_in;
  logic [31:0]   cfg_x0_in, cfg_y0_in, cfg_xn_in, cfg_yn_in, cfg_mag_in;
  logic          cfg_ready_out;
  logic          px_valid_in;
  logic          px_ready_out;
  logic [31:0]   px_x_in, px_y_in;
  logic          res_valid_out;
  logic          res_ready_in;
  logic          res_hit_out;
  logic [IW-1:0] res_idx_out;
  logic [31:0]   res_x_out, res_y_out;
  logic          busy_out;

  always #5 clk_in = ~clk_in;

  line_hit_scheduler #(.NUM_LINES(N), .LINE_WIDTH_SQR(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cfg_we_in(cfg_we_in), .cfg_idx_in(cfg_idx_in), .cfg_en_in(cfg_en_in),
    .cfg_x0_in(cfg_x0_in), .cfg_y0_in(cfg_y0_in), .cfg_xn_in(cfg_xn_in),
    .cfg_yn_in(cfg_yn_in), .cfg_mag_in(cfg_mag_in), .cfg_ready_out(cfg_ready_out),
    .px_valid_in(px_valid_in), .px_ready_out(px_ready_out),
    .px_x_in(px_x_in), .px_y_in(px_y_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_hit_out(res_hit_out), .res_idx_out(res_idx_out),
    .res_x_out(res_x_out), .res_y_out(res_y_out), .busy_out(busy_out)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference table in whole pixels; directions are axis-aligned unit vectors.
  int m_en[N], m_x0[N], m_y0[N], m_xn[N], m_yn[N], m_mag[N];

  function automatic logic [31:0] q(input int v);
    return 32'(v * 65536);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A pixel is on entry k if its projection lies in [0, mag] and its squared
  // distance from the line is at most 4; the lowest enabled such k wins.
  task automatic model_scan(input int px, input int py, output bit hit, output int idx);
    hit = 0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      int dx, dy, t, perp;
      dx   = px - m_x0[k];
      dy   = py - m_y0[k];
      t    = dx * m_xn[k] + dy * m_yn[k];
      perp = dx * m_yn[k] - dy * m_xn[k];
      if (!hit && m_en[k] != 0 && t >= 0 && t <= m_mag[k] && perp * perp <= 4) begin
        hit = 1;
        idx = k;
      end
    end
  endtask

  function automatic int exp_latency(input bit hit, input int idx);
`ifdef LINE_HIT_EARLY_EXIT_EN
    return hit ? idx + 1 : N;
`else
    return N + 0 * (idx + int'(hit));
`endif
  endfunction

  task automatic drive_cfg(input int idx, input int en, input int x0, input int y0,
                           input int xn, input int yn, input int mag);
    cfg_we_in  = 1'b1;
    cfg_idx_in = IW'(idx);
    cfg_en_in  = (en != 0);
    cfg_x0_in  = q(x0);
    cfg_y0_in  = q(y0);
    cfg_xn_in  = q(xn);
    cfg_yn_in  = q(yn);
    cfg_mag_in = q(mag);
  endtask

  task automatic model_write(input int idx, input int en, input int x0, input int y0,
                             input int xn, input int yn, input int mag);
    m_en[idx] = en; m_x0[idx] = x0; m_y0[idx] = y0;
    m_xn[idx] = xn; m_yn[idx] = yn; m_mag[idx] = mag;
  endtask

  task automatic write_entry(input int idx, input int en, input int x0, input int y0,
                             input int xn, input int yn, input int mag);
    @(negedge clk_in);
    drive_cfg(idx, en, x0, y0, xn, yn, mag);
    @(posedge clk_in);
    #1 cfg_we_in = 1'b0;
    model_write(idx, en, x0, y0, xn, yn, mag);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (res_valid_out !== 1'b1 && cyc < 200) begin
      @(posedge clk_in);
      #1 cyc++;
    end
  endtask

  // Checks the DONE outputs, then acknowledges while offering a new pixel,
  // which must not be taken in the acknowledge cycle.
  task automatic finish_result(input string tag, input int px, input int py,
                               input bit hit, input int idx, input int cyc);
    $display("pixel %s (%0d,%0d) hit=%0d idx=%0d latency=%0d exp_hit=%0d exp_idx=%0d",
             tag, px, py, res_hit_out, res_idx_out, cyc, hit, idx);
    check({tag, ".latency"}, 64'(cyc), 64'(exp_latency(hit, idx)));
    check({tag, ".hit"}, 64'(res_hit_out), 64'(hit));
    check({tag, ".idx"}, 64'(res_idx_out), 64'(idx));
    check({tag, ".x"}, 64'(res_x_out), 64'(q(px)));
    check({tag, ".y"}, 64'(res_y_out), 64'(q(py)));
    check({tag, ".px_ready_done"}, 64'(px_ready_out), 64'd0);
    @(negedge clk_in);
    res_ready_in = 1'b1;
    px_valid_in  = 1'b1;
    @(posedge clk_in);
    #1;
    res_ready_in = 1'b0;
    px_valid_in  = 1'b0;
    check({tag, ".valid_after_ack"}, 64'(res_valid_out), 64'd0);
    check({tag, ".busy_after_ack"}, 64'(busy_out), 64'd0);
  endtask

  task automatic do_pixel(input string tag, input int px, input int py);
    bit hit;
    int idx, cyc;
    model_scan(px, py, hit, idx);
    @(negedge clk_in);
    px_x_in = q(px);
    px_y_in = q(py);
    px_valid_in = 1'b1;
    @(posedge clk_in);
    #1 px_valid_in = 1'b0;
    check({tag, ".busy"}, 64'(busy_out), 64'd1);
    wait_result(cyc);
    finish_result(tag, px, py, hit, idx, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int idx, cyc, bad;

    rst_in = 1'b1; cfg_we_in = 1'b0; cfg_idx_in = '0; cfg_en_in = 1'b0;
    cfg_x0_in = '0; cfg_y0_in = '0; cfg_xn_in = '0; cfg_yn_in = '0; cfg_mag_in = '0;
    px_valid_in = 1'b0; px_x_in = '0; px_y_in = '0; res_ready_in = 1'b0;
    for (int k = 0; k < N; k++) model_write(k, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk_in);
    #1;
    check("rst.px_ready", 64'(px_ready_out), 64'd0);
    check("rst.cfg_ready", 64'(cfg_ready_out), 64'd0);
    check("rst.valid", 64'(res_valid_out), 64'd0);
    check("rst.hit", 64'(res_hit_out), 64'd0);
    check("rst.idx", 64'(res_idx_out), 64'd0);
    check("rst.x", 64'(res_x_out), 64'd0);
    check("rst.y", 64'(res_y_out), 64'd0);
    check("rst.busy", 64'(busy_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1 check("idle.px_ready", 64'(px_ready_out), 64'd1);

    // Empty table: full scan, no hit.
    do_pixel("empty", 10, 0);

    // Single horizontal segment at entry 3.
    write_entry(3, 1, 0, 0, 1, 0, 100);
    do_pixel("e3_on", 10, 0);
    do_pixel("e3_far", 10, 5);
    do_pixel("e3_edge_d2", 10, 2);
    do_pixel("e3_d3", 10, -3);
    do_pixel("e3_end", 100, 0);
    do_pixel("e3_past", 101, 0);
    do_pixel("e3_before", -1, 0);

    // Overlapping hits: lowest index wins.
    write_entry(2, 1, 0, 0, 1, 0, 100);
    write_entry(5, 1, 10, -5, 0, 1, 20);
    do_pixel("multi", 10, 0);
    write_entry(2, 0, 0, 0, 1, 0, 100);
    write_entry(3, 0, 0, 0, 1, 0, 100);
    do_pixel("last_only", 10, 10);
    write_entry(7, 1, 40, 40, -1, 0, 5);
    do_pixel("idx7", 37, 41);

    // Write and pixel accept on the same edge.
    @(negedge clk_in);
    drive_cfg(0, 1, 50, 50, 0, -1, 4);
    px_x_in = q(50); px_y_in = q(48); px_valid_in = 1'b1;
    @(posedge clk_in);
    #1 cfg_we_in = 1'b0; px_valid_in = 1'b0;
    model_write(0, 1, 50, 50, 0, -1, 4);
    model_scan(50, 48, hit, idx);
    wait_result(cyc);
    finish_result("same_edge", 50, 48, hit, idx, cyc);

    // Stall in DONE: outputs hold, no new work, table writes ignored.
    write_entry(0, 0, 0, 0, 0, 0, 0);
    write_entry(5, 0, 0, 0, 0, 0, 0);
    write_entry(7, 0, 0, 0, 0, 0, 0);
    write_entry(3, 1, 0, 0, 1, 0, 100);
    model_scan(10, 0, hit, idx);
    @(negedge clk_in);
    px_x_in = q(10); px_y_in = q(0); px_valid_in = 1'b1;
    @(posedge clk_in);
    #1 px_valid_in = 1'b0;
    wait_result(cyc);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      drive_cfg(3, 0, 0, 0, 1, 0, 100);
      px_x_in = q(1); px_y_in = q(1); px_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      if (res_valid_out !== 1'b1 || res_hit_out !== hit || res_idx_out !== IW'(idx) ||
          res_x_out !== q(10) || res_y_out !== q(0) || px_ready_out !== 1'b0 ||
          cfg_ready_out !== 1'b0)
        bad++;
    end
    cfg_we_in = 1'b0; px_valid_in = 1'b0;
    check("stall.stable_cycles_bad", 64'(bad), 64'd0);
    finish_result("stall", 10, 0, hit, idx, cyc);
    do_pixel("after_ignored_write", 10, 0);

    // Reset while scanning entry 4.
    @(negedge clk_in);
    px_x_in = q(10); px_y_in = q(0); px_valid_in = 1'b1;
    @(posedge clk_in);
    #1 px_valid_in = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("midrst.busy", 64'(busy_out), 64'd0);
    check("midrst.valid", 64'(res_valid_out), 64'd0);
    check("midrst.px_ready_in_rst", 64'(px_ready_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < N; k++) m_en[k] = 0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_in);
      #1 if (res_valid_out !== 1'b0 || busy_out !== 1'b0) bad++;
    end
    check("midrst.no_result", 64'(bad), 64'd0);
    do_pixel("after_rst", 10, 0);

    // Randomized tables and pixels, biased toward landing near segments.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < N; k++) begin
        int d, xn, yn;
        d = int'($urandom_range(3));
        xn = (d == 0) ? 1 : (d == 1) ? -1 : 0;
        yn = (d == 2) ? 1 : (d == 3) ? -1 : 0;
        write_entry(k, int'($urandom_range(1)), int'($urandom_range(16)) - 8,
                    int'($urandom_range(16)) - 8, xn, yn, int'($urandom_range(12)));
      end
      for (int p = 0; p < 3; p++) begin
        int k, t, off, px, py;
        k   = int'($urandom_range(N - 1));
        t   = int'($urandom_range(16)) - 2;
        off = int'($urandom_range(6)) - 3;
        px  = m_x0[k] + m_xn[k] * t - m_yn[k] * off;
        py  = m_y0[k] + m_yn[k] * t + m_xn[k] * off;
        do_pixel($sformatf("rnd%0d_%0d", it, p), px, py);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
